wired_cdb_arbiter: RTL

Merges result streams from the execution clusters (ALU0, ALU1, LSU commit FIFO, MDU) onto the two-lane common data bus. Each cycle it grants at most two producers, with fixed priority ALU > LSU > MDU. The two grants must target different ROB banks. An aging override prevents low-priority producers from starving. The outputs are registered and drive the cdb_i snoop ports of every IQ and the ROB write ports.

---
 rtl/wired_cdb_arbiter_if.sv | 37 +++
 rtl/wired_cdb_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/wired_cdb_arbiter_if.sv
// rtl/wired_cdb_arbiter_if.sv - CDB payload type and arbiter port bundle
package wired_cdb_pkg;

  // One CDB beat: result tag, data and exception flag; valid marks a live beat
  typedef struct packed {
    logic        valid;
    logic [7:0]  wid;
    logic [31:0] wdata;
    logic        excp;
  } pipeline_cdb_t;

endpackage

interface wired_cdb_arbiter_if #(
  parameter int SRC_CNT = 4
) ();
  logic                                        flush_i;
  wired_cdb_pkg::pipeline_cdb_t [SRC_CNT-1:0]  src_cdb_i;
  logic [SRC_CNT-1:0]                          src_ready_o;
  wired_cdb_pkg::pipeline_cdb_t [1:0]          cdb_o;

  // Arbiter side
  modport slave (
    input  flush_i,
    input  src_cdb_i,
    output src_ready_o,
    output cdb_o
  );

  // Producer / consumer side
  modport master (
    output flush_i,
    output src_cdb_i,
    input  src_ready_o,
    input  cdb_o
  );
endinterface

// File: rtl/wired_cdb_arbiter.sv
// rtl/wired_cdb_arbiter.sv - two-lane CDB arbiter with bank split and anti-starvation aging
module wired_cdb_arbiter
  import wired_cdb_pkg::*;
#(
  parameter int SRC_CNT      = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int BANK_BIT     = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  wired_cdb_arbiter_if.slave   bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int SW = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;

  logic [CW-1:0]        wait_q [SRC_CNT];
  logic [CW-1:0]        wait_d [SRC_CNT];
  pipeline_cdb_t [1:0]  cdb_q;
  pipeline_cdb_t [1:0]  cdb_d;

  logic [SRC_CNT-1:0]   valid_v;
  logic [SRC_CNT-1:0]   urgent_v;
  logic [2*SRC_CNT-1:0] req_v;
  logic                 a_found;
  logic                 b_found;
  logic [SW-1:0]        a_idx;
  logic [SW-1:0]        b_idx;
  logic                 bank_a;
  logic [SRC_CNT-1:0]   grant_v;
  logic                 dup_wid;

  assign bus.cdb_o       = cdb_q;
  assign bus.src_ready_o = grant_v;

  // Two-pass find-first: urgent sources occupy the low half of req_v, normal ones the high half
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    grant_v = '0;
    for (int i = 0; i < SRC_CNT; i++) begin
      valid_v[i]  = bus.src_cdb_i[i].valid;
      urgent_v[i] = (wait_q[i] == CW'(STARVE_LIMIT));
    end
    req_v = {valid_v & ~urgent_v, valid_v & urgent_v};
    for (int k = 0; k < 2*SRC_CNT; k++) begin
      if (!a_found && req_v[k]) begin
        a_found = 1'b1;
        a_idx   = SW'(k % SRC_CNT);
      end
    end
    bank_a = bus.src_cdb_i[a_idx].wid[BANK_BIT];
    // Lane 1 only takes a source from the opposite ROB bank
    for (int k = 0; k < 2*SRC_CNT; k++) begin
      if (a_found && !b_found && req_v[k] &&
          (bus.src_cdb_i[SW'(k % SRC_CNT)].wid[BANK_BIT] != bank_a)) begin
        b_found = 1'b1;
        b_idx   = SW'(k % SRC_CNT);
      end
    end
    if (!bus.flush_i) begin
      if (a_found) grant_v[a_idx] = 1'b1;
      if (b_found) grant_v[b_idx] = 1'b1;
    end
  end

  // Next lane contents and per-source wait counters
  always_comb begin
    cdb_d  = cdb_q;
    wait_d = wait_q;
    if (bus.flush_i) begin
      cdb_d[0].valid = 1'b0;
      cdb_d[1].valid = 1'b0;
      for (int i = 0; i < SRC_CNT; i++) wait_d[i] = '0;
    end else begin
      if (a_found) cdb_d[0] = bus.src_cdb_i[a_idx];
      else         cdb_d[0].valid = 1'b0;
      if (b_found) cdb_d[1] = bus.src_cdb_i[b_idx];
      else         cdb_d[1].valid = 1'b0;
      for (int i = 0; i < SRC_CNT; i++) begin
        if (valid_v[i] && !grant_v[i]) begin
          if (wait_q[i] != CW'(STARVE_LIMIT)) wait_d[i] = wait_q[i] + CW'(1);
        end else begin
          wait_d[i] = '0;
        end
      end
    end
  end

  // State registers; only lane valids and counters are reset, payload is don't-care
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_q[0].valid <= 1'b0;
      cdb_q[1].valid <= 1'b0;
      for (int i = 0; i < SRC_CNT; i++) wait_q[i] <= '0;
    end else begin
      cdb_q  <= cdb_d;
      wait_q <= wait_d;
    end
  end

  // Two live producers must never carry the same ROB tag
  always_comb begin
    dup_wid = 1'b0;
    for (int i = 0; i < SRC_CNT; i++) begin
      for (int j = i + 1; j < SRC_CNT; j++) begin
        if (valid_v[i] && valid_v[j] &&
            (bus.src_cdb_i[i].wid == bus.src_cdb_i[j].wid)) dup_wid = 1'b1;
      end
    end
  end

  // Flag duplicate tags in simulation
  always_ff @(posedge clk) begin
    if (rst_n) assert (!dup_wid);
  end

endmodule
